bcd_down_timer: RTL
===================

// Module: bcd_down_timer
// PURPOSE
//  Two-digit BCD countdown timer: the down-counting counterpart of the 00-99 up-counter.
//  Loads a preset (00-99), decrements once per prescaled tick while enabled, stops at 00
//  and flags expiry. Drives two active-low 7-segment digits for the board HEX displays.
//  Single clock domain: the prescaler generates a clock enable, never a derived clock.
// PARAMETERS
//  TICK_DIV  50000000  clk cycles per decrement (1 Hz at 50 MHz); must be >= 2
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  clr_n        in   1  synchronous active-low reset/clear
//  load         in   1  level; load preset digits, return to IDLE
//  preset_tens  in   4  BCD preset, tens digit
//  preset_units in   4  BCD preset, units digit
//  s_p          in   1  run(1)/pause(0) level (SW[1])
//  tens         out  4  current tens digit
//  units        out  4  current units digit
//  done         out  1  high while in DONE (count reached 00)
//  expire       out  1  one-clk pulse on the 01->00 transition
//  Hex1         out  7  active-low segments {g..a} of tens
//  Hex0         out  7  active-low segments {g..a} of units
// BEHAVIOUR
//  - Reset (clr_n=0 at posedge): tens=units=0, done=0, expire=0, prescaler=0, state IDLE,
//    Hex1=Hex0=7'b1000000 ("0"). clr_n has priority over load and everything else.
//  - Priority below reset: load > state machine. load=1: tens/units <= preset, each
//    digit >9 clamped to 9; prescaler<=0; state<=IDLE; expire<=0. Valid in any state.
//  - States: IDLE, RUN, DONE.
//    IDLE: s_p=1 and {tens,units}!=00 -> RUN; s_p=1 with 00 stays IDLE (no expire).
//    RUN : s_p=0 -> IDLE (digits hold). On tick: decrement; if value was 01 -> DONE.
//    DONE: digits hold 00, done=1; s_p ignored; left only via load or clr_n.
//  - Prescaler: counts 0..TICK_DIV-1 only in RUN; tick = (cnt==TICK_DIV-1) & RUN, then
//    wraps to 0. Cleared whenever not in RUN, so pausing discards the partial period and the
//    first decrement lands exactly TICK_DIV cycles after entering RUN.
//  - Decrement: units==0 -> units=9, tens=tens-1; else units=units-1. Never below 00.
//  - expire: registered, high for exactly the one cycle in which state first reads DONE.
//  - Hex1/Hex0: registered encode of tens/units, one clk behind the digits; code >9 ->
//    7'b1111111 (blank; unreachable after clamping). Encoding table matches up-counter.
//  - Width: prescaler $clog2(TICK_DIV) bits; all digit arithmetic in 4-bit BCD.
// STRUCTURE
//  - Shared package: state enum {IDLE,RUN,DONE}, SEG_* 7-bit active-low digit constants,
//    SEG_BLANK.
//  - One sub-module: bcd_to_seg7 (4-bit BCD in, 7-bit active-low out, combinational),
//    instantiated twice; same block reusable by the up-counter.
//  - Top: prescaler, FSM + digit registers, output registers.
// TESTING (bench uses TICK_DIV=4)
//  1 clr_n=0 two cycles -> tens=units=0, done=0, expire=0, Hex1=Hex0=7'b1000000.
//  2 load 1,2 then s_p=1 -> 11 at +4 clk, 10 at +8, 09 at +12 (borrow), Hex1=7'b1000000,
//    Hex0=7'b0010000 one cycle later.
//  3 load 0,2, s_p=1 -> 01 at +4, 00 at +8; expire high 1 cycle, done=1; 20 more cycles hold 00.
//  4 run from 05, s_p=0 at cycle 6 (value 04) -> holds 04; s_p=1 -> 03 exactly 4 cycles later.
//  5 load 4'hF,4'hC -> digits 9,9; load 0,0 with s_p=1 -> stays IDLE, expire never asserts.
//  6 clr_n=0 together with load=1 mid-RUN -> reset values win; load during RUN -> IDLE, new preset.

Source files
------------

// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its 7-segment decoder.
//   state_t     : timer state (IDLE, RUN, DONE)
//   SEG_*       : active-low {g..a} segment patterns for digits 0-9
//   SEG_BLANK   : all segments off
//   clamp_bcd() : limits a 4-bit code to a legal BCD digit (>9 -> 9)
package bcd_down_timer_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_down_timer_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 blank the digit.
//   bcd   : 4-bit BCD digit in
//   seg_c : active-low segments {g..a}
module bcd_to_seg7
   import bcd_down_timer_pkg::*;
(
   input  logic [DIGIT_W-1:0] bcd,
   output logic [SEG_W-1:0]   seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (bcd)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with prescaled clock enable and 7-segment outputs.
//   clk, clr_n               : clock, synchronous active-low clear
//   load, preset_tens/units  : load (clamped) preset and return to IDLE
//   s_p                      : run(1)/pause(0) level
//   tens, units              : current BCD digits
//   done, expire             : DONE-state flag, one-cycle 01->00 pulse
//   Hex1, Hex0               : registered active-low segments of tens/units
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               load,
   input  logic [DIGIT_W-1:0] preset_tens,
   input  logic [DIGIT_W-1:0] preset_units,
   input  logic               s_p,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] units,
   output logic               done,
   output logic               expire,
   output logic [SEG_W-1:0]   Hex1,
   output logic [SEG_W-1:0]   Hex0
);

   localparam int unsigned         CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TICK_DIV - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              tick_c;
   logic [SEG_W-1:0]  seg_tens_c;
   logic [SEG_W-1:0]  seg_units_c;

   // Clock enable: last prescaler count while running.
   assign tick_c = (state == RUN) && (cnt == CNT_MAX);

   bcd_to_seg7 u_seg_tens  (.bcd(tens),  .seg_c(seg_tens_c));
   bcd_to_seg7 u_seg_units (.bcd(units), .seg_c(seg_units_c));

   // Prescaler, FSM, digit registers and registered display outputs.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state  <= IDLE;
         cnt    <= '0;
         tens   <= '0;
         units  <= '0;
         done   <= 1'b0;
         expire <= 1'b0;
         Hex1   <= SEG_0;
         Hex0   <= SEG_0;
      end else begin
         Hex1   <= seg_tens_c;
         Hex0   <= seg_units_c;
         expire <= 1'b0;
         if (load) begin
            tens  <= clamp_bcd(preset_tens);
            units <= clamp_bcd(preset_units);
            cnt   <= '0;
            state <= IDLE;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (s_p && ({tens, units} != 8'h00)) state <= RUN;
               end
               RUN: begin
                  if (!s_p) begin
                     // Pause discards the partial prescaler period.
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (tick_c) begin
                     cnt <= '0;
                     if (units == 4'd0) begin
                        units <= 4'd9;
                        tens  <= tens - 4'd1;
                     end else begin
                        units <= units - 4'd1;
                     end
                     if ((tens == 4'd0) && (units == 4'd1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        expire <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               DONE: cnt <= '0;
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
